mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data load/store.
// Data wins by default; a waiting fetch is forced through after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        flush_i,
  input  logic        d_read_i,
  input  logic        d_write_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        if_ready_o,
  output logic [31:0] if_rdata_o,
  output logic        d_ready_o,
  output logic [31:0] d_rdata_o,
  output logic        if_stall_o,
  output logic        d_stall_o
);

  typedef enum logic [1:0] {StIdle, StIfBusy, StDBusy, StDone} state_e;

  localparam logic [2:0] LimitCnt = 3'(STARVE_LIMIT);

  state_e      r_state_q, w_state_d;
  logic [2:0]  r_starve_q, w_starve_d;
  logic        r_mem_req_q, w_mem_req_d;
  logic        r_mem_we_q, w_mem_we_d;
  logic [31:0] r_mem_addr_q, w_mem_addr_d;
  logic [31:0] r_mem_wdata_q, w_mem_wdata_d;
  logic [31:0] r_if_rdata_q, w_if_rdata_d;
  logic [31:0] r_d_rdata_q, w_d_rdata_d;
  logic        r_done_if_q, w_done_if_d;
  logic        r_flushed_q, w_flushed_d;

  logic w_d_req;
  logic w_fetch_forced;

  assign w_d_req        = d_read_i | d_write_i;
  assign w_fetch_forced = if_req_i && (r_starve_q == LimitCnt);

  always_comb begin
    w_state_d     = r_state_q;
    w_starve_d    = r_starve_q;
    w_mem_req_d   = r_mem_req_q;
    w_mem_we_d    = r_mem_we_q;
    w_mem_addr_d  = r_mem_addr_q;
    w_mem_wdata_d = r_mem_wdata_q;
    w_if_rdata_d  = r_if_rdata_q;
    w_d_rdata_d   = r_d_rdata_q;
    w_done_if_d   = r_done_if_q;
    w_flushed_d   = r_flushed_q;
    unique case (r_state_q)
      StIdle: begin
        w_flushed_d = 1'b0;
        if (w_d_req && !w_fetch_forced) begin
          w_state_d     = StDBusy;
          w_mem_req_d   = 1'b1;
          // A simultaneous read and write is a store.
          w_mem_we_d    = d_write_i;
          w_mem_addr_d  = d_addr_i;
          w_mem_wdata_d = d_write_i ? d_wdata_i : 32'h0;
          w_done_if_d   = 1'b0;
          if (if_req_i && (r_starve_q != LimitCnt)) begin
            w_starve_d = r_starve_q + 3'd1;
          end
        end else if (if_req_i) begin
          w_state_d     = StIfBusy;
          w_mem_req_d   = 1'b1;
          w_mem_we_d    = 1'b0;
          w_mem_addr_d  = if_addr_i;
          w_mem_wdata_d = 32'h0;
          w_done_if_d   = 1'b1;
          w_starve_d    = 3'd0;
        end
      end
      StIfBusy: begin
        // A flush anywhere up to and including the ack cycle kills the result.
        if (flush_i) begin
          w_flushed_d = 1'b1;
        end
        if (mem_ack_i) begin
          w_state_d   = StDone;
          w_mem_req_d = 1'b0;
          w_mem_we_d  = 1'b0;
          if (!(flush_i || r_flushed_q)) begin
            w_if_rdata_d = mem_rdata_i;
          end
        end
      end
      StDBusy: begin
        if (mem_ack_i) begin
          w_state_d   = StDone;
          w_mem_req_d = 1'b0;
          w_mem_we_d  = 1'b0;
          if (!r_mem_we_q) begin
            w_d_rdata_d = mem_rdata_i;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q     <= StIdle;
      r_starve_q    <= 3'd0;
      r_mem_req_q   <= 1'b0;
      r_mem_we_q    <= 1'b0;
      r_mem_addr_q  <= 32'h0;
      r_mem_wdata_q <= 32'h0;
      r_if_rdata_q  <= 32'h0;
      r_d_rdata_q   <= 32'h0;
      r_done_if_q   <= 1'b0;
      r_flushed_q   <= 1'b0;
    end else begin
      r_state_q     <= w_state_d;
      r_starve_q    <= w_starve_d;
      r_mem_req_q   <= w_mem_req_d;
      r_mem_we_q    <= w_mem_we_d;
      r_mem_addr_q  <= w_mem_addr_d;
      r_mem_wdata_q <= w_mem_wdata_d;
      r_if_rdata_q  <= w_if_rdata_d;
      r_d_rdata_q   <= w_d_rdata_d;
      r_done_if_q   <= w_done_if_d;
      r_flushed_q   <= w_flushed_d;
    end
  end

  assign mem_req_o   = r_mem_req_q;
  assign mem_we_o    = r_mem_we_q;
  assign mem_addr_o  = r_mem_addr_q;
  assign mem_wdata_o = r_mem_wdata_q;
  assign if_rdata_o  = r_if_rdata_q;
  assign d_rdata_o   = r_d_rdata_q;
  assign if_ready_o  = (r_state_q == StDone) && r_done_if_q && !r_flushed_q;
  assign d_ready_o   = (r_state_q == StDone) && !r_done_if_q;
  assign if_stall_o  = if_req_i & ~if_ready_o;
  assign d_stall_o   = w_d_req & ~d_ready_o;

endmodule
